// File: rtl/pwm_multi.sv
// Multi-channel double-buffered PWM generator: one shared period counter,
// per-channel shadowed duty registers that load only at period boundaries.
module pwm_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned BITS      = 8,
  parameter int unsigned CHAN_BITS = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BITS-1:0]      period,
  input  logic                 wr_en,
  input  logic [CHAN_BITS-1:0] wr_chan,
  input  logic [BITS-1:0]      wr_data,
  output logic [CHANNELS-1:0]  out,
  output logic                 period_start
);

  logic [BITS-1:0]     cnt;
  logic [BITS-1:0]     per_act;
  logic [BITS-1:0]     shadow   [CHANNELS];
  logic [BITS-1:0]     duty_act [CHANNELS];
  logic                load_c;
  logic [CHANNELS-1:0] hit_c;

  // Active values reload every idle cycle and at each wrap while running.
  assign load_c = !enable || (cnt == per_act);

  // Out-of-range channel indices match no channel, so such writes are dropped.
  always_comb begin
    hit_c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hit_c[i] = wr_en && (32'(wr_chan) == i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      per_act      <= '0;
      period_start <= 1'b0;
    end else begin
      // Flags the cycle whose outputs reflect cnt=0, i.e. the first of a period.
      period_start <= enable && (cnt == '0);
      if (load_c) begin
        cnt     <= '0;
        per_act <= period;
      end else begin
        cnt <= cnt + BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shadow[i]   <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (hit_c[i]) begin
          shadow[i] <= wr_data;
        end
        // A write landing on a load cycle bypasses the shadow.
        if (load_c) begin
          duty_act[i] <= hit_c[i] ? wr_data : shadow[i];
        end
        out[i] <= enable && (duty_act[i] > cnt);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: per-period vector table, hand sequences
// for buffering/abort/reset corners, and a randomized run against a model.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] period = 8'd0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_chan = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [3:0] out;
  logic       period_start;

  int n_pass = 0;
  int n_total = 0;
  bit mon_on = 1'b0;

  pwm_multi #(.CHANNELS(4), .BITS(8), .CHAN_BITS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: position within the period, shadow duties, and the
  // duties/period latched at the most recent boundary.
  int       m_pos, m_len_m1;
  int       m_sh[4], m_duty[4];
  bit [3:0] m_out;
  bit       m_ps;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pos = 0; m_len_m1 = 0; m_out = '0; m_ps = 1'b0;
      for (int i = 0; i < 4; i++) begin m_sh[i] = 0; m_duty[i] = 0; end
    end else begin
      for (int i = 0; i < 4; i++) m_out[i] = enable && (m_duty[i] > m_pos);
      m_ps = enable && (m_pos == 0);
      if (wr_en && wr_chan < 3'd4) m_sh[wr_chan] = int'(wr_data);
      if (!enable || m_pos == m_len_m1) begin
        m_pos = 0;
        m_len_m1 = int'(period);
        m_duty = m_sh;
      end else begin
        m_pos = m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("model_out", int'(out), int'(m_out));
      check("model_period_start", int'(period_start), int'(m_ps));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic wr(input logic [2:0] ch, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_chan = ch; wr_data = d;
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  // Measures one period from a period_start cycle to the next; optionally
  // issues a write at cycle wr_at of that period. Call at a negedge.
  task automatic measure(input int wr_at, input logic [2:0] ch, input logic [7:0] d,
                         output int hi[4], output int len, output logic [3:0] first);
    int t;
    for (int i = 0; i < 4; i++) hi[i] = 0;
    len = 0; t = 0; first = '0;
    while (period_start !== 1'b1 && t < 600) begin @(negedge clk); t++; end
    if (t >= 600) begin check("wait_period_start", 0, 1); return; end
    first = out;
    do begin
      for (int i = 0; i < 4; i++) hi[i] += int'(out[i]);
      if (len == wr_at) begin wr_en = 1'b1; wr_chan = ch; wr_data = d; end
      len++;
      @(posedge clk); #1 wr_en = 1'b0;
      @(negedge clk);
    end while (period_start !== 1'b1 && len < 600);
  endtask

  typedef struct {
    logic [7:0] per;
    logic [7:0] d[4];
    int         hi[4];
    int         len;
  } vec_t;

  vec_t       tbl[5];
  int         hi[4];
  int         len;
  logic [3:0] first;
  logic [3:0] mask;

  initial begin
    tbl[0].per = 8'd9;   tbl[0].d = '{8'd0, 8'd3, 8'd10, 8'd5};   tbl[0].hi = '{0, 3, 10, 5};    tbl[0].len = 10;
    tbl[1].per = 8'd4;   tbl[1].d = '{8'd7, 8'd0, 8'd4, 8'd5};    tbl[1].hi = '{5, 0, 4, 5};     tbl[1].len = 5;
    tbl[2].per = 8'd0;   tbl[2].d = '{8'd0, 8'd1, 8'd2, 8'd0};    tbl[2].hi = '{0, 1, 1, 0};     tbl[2].len = 1;
    tbl[3].per = 8'd255; tbl[3].d = '{8'd255, 8'd0, 8'd128, 8'd1}; tbl[3].hi = '{255, 0, 128, 1}; tbl[3].len = 256;
    tbl[4].per = 8'd1;   tbl[4].d = '{8'd1, 8'd2, 8'd0, 8'd255};  tbl[4].hi = '{1, 2, 0, 2};     tbl[4].len = 2;

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_on = 1'b1;
    check("reset_out", int'(out), 0);
    check("reset_period_start", int'(period_start), 0);

    // Idle with writes to every channel index: outputs stay low.
    for (int c = 0; c < 20; c++) begin
      wr(3'(c % 8), 8'($urandom_range(1, 255)));
      @(negedge clk);
      check("idle_out", int'(out), 0);
      check("idle_period_start", int'(period_start), 0);
    end

    foreach (tbl[v]) begin
      @(negedge clk); enable = 1'b0;
      for (int i = 0; i < 4; i++) wr(3'(i), tbl[v].d[i]);
      @(negedge clk); period = tbl[v].per;
      @(negedge clk); enable = 1'b1;
      @(negedge clk);
      measure(-1, 3'd0, 8'd0, hi, len, first);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("vec%0d_high_ch%0d", v, i), hi[i], tbl[v].hi[i]);
        mask[i] = (tbl[v].hi[i] > 0);
      end
      check($sformatf("vec%0d_len", v), len, tbl[v].len);
      check($sformatf("vec%0d_first_out", v), int'(first), int'(mask));
    end

    // Double buffering, including a write landing exactly on the wrap cycle.
    @(negedge clk); enable = 1'b0;
    wr(3'd0, 8'd0); wr(3'd1, 8'd3); wr(3'd2, 8'd10); wr(3'd3, 8'd5);
    @(negedge clk); period = 8'd9;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    measure(3, 3'd1, 8'd7, hi, len, first);
    check("dbuf_cur_period", hi[1], 3);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("dbuf_next_period", hi[1], 7);
    measure(8, 3'd1, 8'd2, hi, len, first);
    check("dbuf_wrap_cur", hi[1], 7);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("dbuf_wrap_bypass", hi[1], 2);

    // Period change mid-period only takes hold at the next wrap.
    period = 8'd4;
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("perchg_cur_len", len, 10);
    measure(0, 3'd0, 8'd7, hi, len, first);
    check("perchg_new_len", len, 5);
    check("perchg_ch2_high", hi[2], 5);
    measure(1, 3'd5, 8'd1, hi, len, first);
    check("perchg_duty7_const_high", hi[0], 5);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("badchan_ch0", hi[0], 5);
    check("badchan_ch1", hi[1], 2);
    check("badchan_ch2", hi[2], 5);
    check("badchan_ch3", hi[3], 5);

    // Abort by dropping enable at cnt=5, then restart from cnt=0.
    period = 8'd9;
    measure(-1, 3'd0, 8'd0, hi, len, first);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_out", int'(out), 0);
    check("abort_period_start", int'(period_start), 0);
    enable = 1'b1;
    @(negedge clk);
    check("restart_period_start", int'(period_start), 1);
    check("restart_out", int'(out), 4'hF);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("restart_len", len, 10);
    check("restart_ch0_high", hi[0], 7);

    // Asynchronous reset between edges while ch2 is high.
    check("pre_reset_ch2", int'(out[2]), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_out", int'(out), 0);
    check("async_reset_period_start", int'(period_start), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    measure(-1, 3'd0, 8'd0, hi, len, first);
    check("post_reset_len", len, 10);
    check("post_reset_all_low", hi[0] + hi[1] + hi[2] + hi[3], 0);

    // Randomized traffic; the negedge monitor compares against the model.
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) period = 8'($urandom_range(0, 12));
      wr_en = ($urandom_range(0, 3) == 0);
      wr_chan = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom_range(0, 15));
    end
    @(negedge clk); #1;
    reset = 1'b0; wr_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel, double-buffered pulse width modulation generator: the parametrised successor to the single-channel `pwm` core. CHANNELS outputs share one period counter with a programmable period. Each channel has its own duty cycle, written through a simple register port. Duty and period updates are shadowed and take effect only at a period boundary, so outputs never glitch mid-cycle. The block sits behind a bus or I2C register front end, such as an `i2c_slave_reg` decoder, and drives LED, servo and analog-emulation outputs.

## Interface
Parameters:
- CHANNELS, 4, number of independent PWM outputs (1..16)
- BITS, 8, width of the counter, the period and each duty value
- CHAN_BITS, 2, width of wr_chan; must satisfy 2**CHAN_BITS >= CHANNELS

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run control; 0 holds the block idle
- period  in  BITS  counter terminal value; the period length is period+1 clocks
- wr_en  in  1  single-cycle write strobe for a shadow duty register
- wr_chan  in  CHAN_BITS  channel index for the write
- wr_data  in  BITS  duty value for the write
- out  out  CHANNELS  registered PWM outputs
- period_start  out  1  one-cycle pulse marking the first cycle of each period

## Operation
State:
- cnt[BITS-1:0]
- per_act[BITS-1:0]
- shadow[i][BITS-1:0] and duty_act[i][BITS-1:0] for every channel
- out, period_start

Reset:
- All state, including shadow registers and outputs, clears to 0.

Writes:
- When wr_en=1 and wr_chan<CHANNELS, shadow[wr_chan] <= wr_data.
- When wr_chan>=CHANNELS, the write is ignored.
- Writes are accepted regardless of enable.

Idle (enable=0):
- cnt <= 0.
- out <= 0 and period_start <= 0.
- Continuous load: per_act <= period and duty_act[i] <= shadow[i] every cycle, so the first period after enable uses current values.
- When a write lands in this cycle, duty_act for that channel loads wr_data (bypass).

Run (enable=1):
- If cnt == per_act, the cycle is a wrap cycle:
  - cnt <= 0.
  - per_act <= period.
  - duty_act[i] <= shadow[i]. A write to the same channel in the wrap cycle is bypassed, so duty_act gets wr_data.
  - period_start <= 1.
- Otherwise: cnt <= cnt+1 and period_start <= 0.
- out[i] <= (duty_act[i] > cnt). The comparison is unsigned, BITS wide.

Comparison rules:
- duty 0 gives a constant low output.
- duty in 1..per_act gives duty high clocks per period of per_act+1 clocks.
- duty > per_act gives a constant high output; 100% is reachable only when per_act < 2**BITS-1.
- period=0 gives a 1-clock period: cnt stays 0 and period_start stays high every cycle.

Other rules:
- Changing period mid-period has no effect until the next wrap.
- Deasserting enable mid-period aborts the period; the next enable starts at cnt=0.

## Timing
- Output latency: out and period_start are registered, one clock after the cnt value they reflect.
- High time: out[i] is high for the duty_act[i] cycles following each period_start-aligned boundary.
- Period-start alignment: period_start is high in the same cycle that out reflects cnt=0.
- Write-to-effect latency: a write reaches the output in the first period after the next wrap, and no earlier. Best case is a write in the wrap cycle, visible 2 clocks later.
- Enable start-up: the first cycle after enable rises is cnt=0. The first out reflecting it, with period_start=1, appears 2 clocks after the enable edge.
- Reset: reset asserted mid-period forces all outputs low immediately, without waiting for a clock.

## Test plan
- Reset/idle:
  - Stimulus: reset, then enable=0 for 20 clocks with writes to all channels.
  - Required response: out=0 and period_start=0 throughout.
- Basic duty:
  - Stimulus: CHANNELS=4, BITS=8, period=9; duties 0, 3, 10, 5 written while idle; then enable=1.
  - Required response: each 10-clock period has ch0 always low, ch1 high 3 clocks, ch2 always high, ch3 high 5 clocks.
  - Required response: period_start pulses every 10 clocks, coincident with the rising edges of ch1 and ch3.
- Double buffering:
  - Stimulus: write ch1=7 at cnt=4 of a running period.
  - Required response: the current period still shows 3 high clocks; the next period shows 7.
  - Stimulus: write ch1=2 exactly in the wrap cycle.
  - Required response: the next period shows 2 (bypass).
- Period change:
  - Stimulus: change period from 9 to 4 mid-period.
  - Required response: the current period completes at 10 clocks, and subsequent periods are 5 clocks.
  - Required response: a duty of 7 becomes constant high.
- Boundaries:
  - Stimulus: period=0.
  - Required response: period_start is constantly 1, and out[i]=1 exactly when duty>0.
  - Stimulus: period=255 with duty=255.
  - Required response: 255 of 256 clocks are high.
  - Stimulus: a write with wr_chan=3 when CHANNELS=3.
  - Required response: no channel changes.
- Abort and async reset:
  - Stimulus: drop enable at cnt=5.
  - Required response: out=0 the next clock; on re-enable, the timing restarts from cnt=0.
  - Stimulus: pulse reset between clock edges while out=1.
  - Required response: out falls without a clock edge, and shadows read back as 0, giving all-low periods.
